// File: rtl/selftest_pkg.sv
// -----------------------------------------------------------------------------
// selftest_pkg
// Shared definitions for the AND-gate self-test sequencer.
//   state_t        : sequencer state encoding (2 bits)
//   NUM_VECTORS    : number of input vectors applied per run
//   LAST_IDX       : index of the final vector
//   expected_out() : golden AND response for a vector index
// -----------------------------------------------------------------------------
package selftest_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_CHECK  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam int NUM_VECTORS = 4;
    localparam logic [1:0] LAST_IDX = 2'(NUM_VECTORS - 1);

    // Vector idx drives A=idx[1], B=idx[0]; a good AND gate returns A&B.
    function automatic logic expected_out(input logic [1:0] idx);
        return idx[1] & idx[0];
    endfunction

endpackage

// File: rtl/settle_timer.sv
// -----------------------------------------------------------------------------
// settle_timer
// Loadable down-counter that stops at zero; o_zero flags terminal count.
// Ports:
//   clk, rst_n  : clock, async active-low reset (count clears to 0)
//   i_load      : load i_value (takes priority over i_tick)
//   i_value     : load value
//   i_tick      : decrement by one when non-zero
//   o_zero      : count == 0
// -----------------------------------------------------------------------------
module settle_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_value,
    input  logic             i_tick,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_value;
        end else if (i_tick && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/gate_selftest_ctrl.sv
// -----------------------------------------------------------------------------
// gate_selftest_ctrl
// Drives the four input vectors (00, 01, 10, 11) into a 2-input AND gate under
// test, holds each for SETTLE_CYCLES, samples the gate output for one cycle and
// records mismatches. All outputs are registered.
//
// Optional macro SELFTEST_LOOP_EN: when defined, DONE lasts one cycle and the
// run restarts automatically; fail_vec is sticky and err_count accumulates,
// saturating at 7. When undefined the controller is single-shot.
//
// Ports:
//   clk, rst_n     : clock, async active-low reset
//   start          : level-sampled run request (IDLE or DONE)
//   abort          : return to IDLE, clearing results (beats start)
//   gate_out       : output of the gate under test
//   drv_a, drv_b   : gate input drivers
//   busy           : SETTLE or CHECK
//   done, pass     : run complete / no vector failed
//   fail_vec[3:0]  : bit i set if vector i mismatched
//   err_count[2:0] : number of mismatches
//
// state  | meaning
// -------+-------------------------------------------------------
// IDLE   | waiting for start, all outputs low
// SETTLE | vector applied, settle timer counting down
// CHECK  | one cycle: compare gate_out with expected value
// DONE   | results valid; wait for start (or auto-restart)
// -----------------------------------------------------------------------------
module gate_selftest_ctrl
    import selftest_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic       gate_out,
    output logic       drv_a,
    output logic       drv_b,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] fail_vec,
    output logic [2:0] err_count
);

    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(SETTLE_CYCLES - 1);

    state_t     r_state;
    logic [1:0] r_idx;
    logic       r_drv_a;
    logic       r_drv_b;
    logic       r_busy;
    logic       r_done;
    logic       r_pass;
    logic [3:0] r_fail_vec;
    logic [2:0] r_err_count;

    state_t     w_state_nxt;
    logic [1:0] w_idx_nxt;
    logic       w_drv_a_nxt;
    logic       w_drv_b_nxt;
    logic       w_busy_nxt;
    logic       w_done_nxt;
    logic       w_pass_nxt;
    logic [3:0] w_fail_vec_nxt;
    logic [2:0] w_err_count_nxt;
    logic       w_launch;
    logic       w_clear_results;
    logic       w_tmr_load;
    logic       w_tmr_tick;
    logic [CNT_W-1:0] w_tmr_value;
    logic       w_tmr_zero;
    logic [1:0] w_idx_inc;

    settle_timer #(
        .CNT_W (CNT_W)
    ) u_settle_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_tmr_load),
        .i_value (w_tmr_value),
        .i_tick  (w_tmr_tick),
        .o_zero  (w_tmr_zero)
    );

    assign w_idx_inc = r_idx + 2'd1;

    always_comb begin
        w_state_nxt     = r_state;
        w_idx_nxt       = r_idx;
        w_drv_a_nxt     = r_drv_a;
        w_drv_b_nxt     = r_drv_b;
        w_busy_nxt      = r_busy;
        w_done_nxt      = r_done;
        w_pass_nxt      = r_pass;
        w_fail_vec_nxt  = r_fail_vec;
        w_err_count_nxt = r_err_count;
        w_launch        = 1'b0;
        w_clear_results = 1'b0;
        w_tmr_load      = 1'b0;
        w_tmr_tick      = 1'b0;
        w_tmr_value     = RELOAD;

        if (abort) begin
            w_state_nxt     = ST_IDLE;
            w_idx_nxt       = 2'd0;
            w_drv_a_nxt     = 1'b0;
            w_drv_b_nxt     = 1'b0;
            w_busy_nxt      = 1'b0;
            w_done_nxt      = 1'b0;
            w_pass_nxt      = 1'b0;
            w_fail_vec_nxt  = 4'd0;
            w_err_count_nxt = 3'd0;
            w_tmr_load      = 1'b1;
            w_tmr_value     = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        w_launch        = 1'b1;
                        w_clear_results = 1'b1;
                    end
                end
                ST_SETTLE: begin
                    w_tmr_tick = 1'b1;
                    if (w_tmr_zero) begin
                        w_state_nxt = ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (gate_out != expected_out(r_idx)) begin
                        w_fail_vec_nxt[r_idx] = 1'b1;
                        if (r_err_count != 3'd7) begin
                            w_err_count_nxt = r_err_count + 3'd1;
                        end
                    end
                    if (r_idx == LAST_IDX) begin
                        w_state_nxt = ST_DONE;
                        w_idx_nxt   = 2'd0;
                        w_drv_a_nxt = 1'b0;
                        w_drv_b_nxt = 1'b0;
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                        // Include the final sample taken this cycle.
                        w_pass_nxt  = (w_fail_vec_nxt == 4'd0);
                    end else begin
                        w_state_nxt = ST_SETTLE;
                        w_idx_nxt   = w_idx_inc;
                        w_drv_a_nxt = w_idx_inc[1];
                        w_drv_b_nxt = w_idx_inc[0];
                        w_tmr_load  = 1'b1;
                    end
                end
                ST_DONE: begin
`ifdef SELFTEST_LOOP_EN
                    // Auto-restart keeps the accumulated results.
                    w_launch = 1'b1;
`else
                    if (start) begin
                        w_launch        = 1'b1;
                        w_clear_results = 1'b1;
                    end
`endif
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase

            if (w_launch) begin
                w_state_nxt = ST_SETTLE;
                w_idx_nxt   = 2'd0;
                w_drv_a_nxt = 1'b0;
                w_drv_b_nxt = 1'b0;
                w_busy_nxt  = 1'b1;
                w_done_nxt  = 1'b0;
                w_pass_nxt  = 1'b0;
                w_tmr_load  = 1'b1;
                if (w_clear_results) begin
                    w_fail_vec_nxt  = 4'd0;
                    w_err_count_nxt = 3'd0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_idx       <= 2'd0;
            r_drv_a     <= 1'b0;
            r_drv_b     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_fail_vec  <= 4'd0;
            r_err_count <= 3'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_idx       <= w_idx_nxt;
            r_drv_a     <= w_drv_a_nxt;
            r_drv_b     <= w_drv_b_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            r_pass      <= w_pass_nxt;
            r_fail_vec  <= w_fail_vec_nxt;
            r_err_count <= w_err_count_nxt;
        end
    end

    assign drv_a     = r_drv_a;
    assign drv_b     = r_drv_b;
    assign busy      = r_busy;
    assign done      = r_done;
    assign pass      = r_pass;
    assign fail_vec  = r_fail_vec;
    assign err_count = r_err_count;

endmodule

// File: tb/tb_gate_selftest_ctrl.sv
// -----------------------------------------------------------------------------
// tb_gate_selftest_ctrl
// Self-checking bench for gate_selftest_ctrl (SETTLE_CYCLES=4). The gate under
// test is modelled as a 4-entry truth table indexed by {drv_a, drv_b}, so any
// faulty gate can be emulated. Loop-mode checks are compiled when
// SELFTEST_LOOP_EN is defined.
// -----------------------------------------------------------------------------
module tb_gate_selftest_ctrl;

    localparam int S       = 4;
    localparam int VEC_LEN = S + 1;
    localparam int RUN_LEN = 4 * VEC_LEN;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       gate_out;
    logic       drv_a, drv_b, busy, done, pass;
    logic [3:0] fail_vec;
    logic [2:0] err_count;
    logic [3:0] gate_tt = 4'b1000;

    int n_tests = 0;
    int n_fail  = 0;

    assign gate_out = gate_tt[{drv_a, drv_b}];

    always #5 clk = ~clk;

    gate_selftest_ctrl #(
        .SETTLE_CYCLES (S),
        .CNT_W         (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .gate_out  (gate_out),
        .drv_a     (drv_a),
        .drv_b     (drv_b),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .fail_vec  (fail_vec),
        .err_count (err_count)
    );

    typedef struct {
        logic [3:0] tt;
        logic [3:0] exp_fail;
        logic [2:0] exp_err;
        logic       exp_pass;
    } vec_t;

    vec_t tbl [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [11:0] snap();
        return {drv_a, drv_b, busy, done, pass, fail_vec, err_count};
    endfunction

    // Reference: a vector fails where the gate's truth table differs from AND.
    function automatic logic [3:0] model_fail(input logic [3:0] tt);
        logic [3:0] and_tt;
        for (int i = 0; i < 4; i++) and_tt[i] = ((i >> 1) & i & 1) != 0;
        return tt ^ and_tt;
    endfunction

    task automatic run_check(input string tag, input logic [3:0] tt,
                             input logic [3:0] exp_fail, input logic [2:0] exp_err,
                             input logic exp_pass);
        gate_tt = tt;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= RUN_LEN; c++) begin
            int v;
            v = (c - 1) / VEC_LEN;
            check({tag, " traj"}, {drv_a, drv_b, busy, done}, {v[1:0], 1'b1, 1'b0});
            step();
        end
        check({tag, " done"}, {busy, done, drv_a, drv_b}, 4'b0100);
        check({tag, " result"}, {pass, fail_vec, err_count}, {exp_pass, exp_fail, exp_err});
    endtask

    task automatic abort_check(input string tag);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check({tag, " abort"}, snap(), 12'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] tt, ef;
        tbl[0] = '{tt: 4'b1000, exp_fail: 4'b0000, exp_err: 3'd0, exp_pass: 1'b1}; // good AND
        tbl[1] = '{tt: 4'b1111, exp_fail: 4'b0111, exp_err: 3'd3, exp_pass: 1'b0}; // stuck-at-1
        tbl[2] = '{tt: 4'b1110, exp_fail: 4'b0110, exp_err: 3'd2, exp_pass: 1'b0}; // OR
        tbl[3] = '{tt: 4'b0000, exp_fail: 4'b1000, exp_err: 3'd1, exp_pass: 1'b0}; // stuck-at-0
        tbl[4] = '{tt: 4'b0110, exp_fail: 4'b1110, exp_err: 3'd3, exp_pass: 1'b0}; // XOR
        tbl[5] = '{tt: 4'b0111, exp_fail: 4'b1111, exp_err: 3'd4, exp_pass: 1'b0}; // NAND

        // Reset state
        #12;
        check("reset outputs", snap(), 12'h0);
        rst_n = 1'b1;
        step();
        step();
        check("idle without start", {snap(), 1'b0}, 13'h0);

        // Table-driven gate models
        for (int i = 0; i < 6; i++) begin
            run_check($sformatf("tbl%0d", i), tbl[i].tt, tbl[i].exp_fail,
                      tbl[i].exp_err, tbl[i].exp_pass);
            abort_check($sformatf("tbl%0d", i));
        end

        // Randomized gate truth tables vs reference
        for (int i = 0; i < 16; i++) begin
            tt = 4'($urandom_range(0, 15));
            ef = model_fail(tt);
            run_check($sformatf("rnd%0d", i), tt, ef, 3'($countones(ef)), ef == 4'd0);
            abort_check($sformatf("rnd%0d", i));
        end

`ifndef SELFTEST_LOOP_EN
        // DONE holds, then start restarts and clears results
        run_check("hold", 4'b1111, 4'b0111, 3'd3, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("done hold", {done, busy, pass, fail_vec, err_count}, {1'b1, 1'b0, 1'b0, 4'b0111, 3'd3});
        end
        gate_tt = 4'b1000;
        start = 1'b1;
        step();
        start = 1'b0;
        check("restart from done", {busy, done, pass, fail_vec, err_count}, {1'b1, 1'b0, 1'b0, 4'd0, 3'd0});
        abort_check("restart");
`endif

        // Abort during vector 2 SETTLE together with start held high
        gate_tt = 4'b1111;
        start = 1'b1;
        step();
        for (int c = 1; c <= 11; c++) begin
            int v;
            v = (c - 1) / VEC_LEN;
            check("start held traj", {drv_a, drv_b, busy, done}, {v[1:0], 1'b1, 1'b0});
            step();
        end
        check("pre-abort fail_vec", {drv_a, drv_b, fail_vec}, {2'b10, 4'b0011});
        abort = 1'b1;
        step();
        check("abort+start", snap(), 12'h0);
        abort = 1'b0;
        start = 1'b0;
        step();
        check("idle after abort", snap(), 12'h0);
        run_check("post-abort", 4'b1000, 4'b0000, 3'd0, 1'b1);
        abort_check("post-abort");

        // Async reset in the middle of vector 1 CHECK
        gate_tt = 4'b1111;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c < 10; c++) step();
        check("pre-reset state", {drv_a, drv_b, busy, fail_vec}, {2'b01, 1'b1, 4'b0001});
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset immediate", snap(), 12'h0);
        step();
        check("reset held", snap(), 12'h0);
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("idle after reset", snap(), 12'h0);
        end
        run_check("post-reset", 4'b1000, 4'b0000, 3'd0, 1'b1);
        abort_check("post-reset");

`ifdef SELFTEST_LOOP_EN
        // Looping with stuck-at-0: done pulses every 21 cycles, err saturates at 7
        gate_tt = 4'b0000;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= 9 * (RUN_LEN + 1); c++) begin
            logic d;
            int loops;
            d = (c % (RUN_LEN + 1)) == 0;
            check("loop done/busy", {busy, done}, {~d, d});
            if (d) begin
                loops = c / (RUN_LEN + 1);
                check("loop results", {pass, fail_vec, err_count},
                      {1'b0, 4'b1000, 3'(loops > 7 ? 7 : loops)});
            end
            step();
        end
        abort_check("loop");
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/gate_selftest_ctrl.md
Name: gate_selftest_ctrl

Overview:
- Sequencer that exercises a 2-input AND gate under test on the FPGA.
- Applies all 4 input vectors in order and waits a programmable settle time per vector.
- Samples the gate output and compares it against the expected a&b.
- Reports per-vector failures, an error count and a final pass/done status; sits between a start source (button/host) and the gate instance.

Parameters:
- SETTLE_CYCLES, 4, clock cycles each vector is held before the output is sampled; legal range 1..255, 0 illegal.
- CNT_W, 8, width of the settle counter; must satisfy 2^CNT_W > SETTLE_CYCLES.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  level-sampled; starts a test run when sampled in IDLE or DONE
- abort  input  1  returns to IDLE from any state
- gate_out  input  1  output of the gate under test
- drv_a  output  1  drives gate input A
- drv_b  output  1  drives gate input B
- busy  output  1  high in SETTLE and CHECK
- done  output  1  test run complete
- pass  output  1  valid when done=1; 1 iff no vector failed
- fail_vec  output  4  bit i set if vector i mismatched
- err_count  output  3  number of mismatching vectors, 0..4

Behaviour:
- Reset (async, rst_n=0): state=IDLE, idx=0, counter=0, all outputs 0.
- Vector i (0..3): drv_a=idx[1], drv_b=idx[0]; expected = idx[1]&idx[0]. Order is 00, 01, 10, 11.
- All outputs are registered; no combinational path from any input to any output.
- States and transitions:
  - IDLE: outputs 0.
    - start=1 → SETTLE with idx=0, drivers=vector 0, counter=SETTLE_CYCLES-1; fail_vec and err_count cleared.
  - SETTLE: counter decrements each cycle.
    - counter==0 → CHECK.
  - CHECK (one cycle): sample gate_out. On mismatch, set fail_vec[idx] and increment err_count.
    - idx==3 → DONE.
    - Otherwise idx+1, drivers updated to the next vector, counter reloaded, → SETTLE.
  - DONE: done=1, pass=(fail_vec==0 including the final sample), drivers return to 0.
    - Holds until start=1 → same as the IDLE start transition (results cleared, done/pass drop next cycle).
- Each vector occupies SETTLE_CYCLES+1 cycles. With start sampled at cycle 0, done rises at cycle 4*(SETTLE_CYCLES+1)+1; 21 for the default.
- busy and done are never both 1.
- abort=1 in any state → IDLE next cycle; drivers, done, pass, fail_vec and err_count cleared.
- abort and start high together: abort wins.
- start held high through a run has no effect until DONE. In DONE it immediately restarts.
- Mid-run async reset: all state cleared at once; drivers go to 0 without waiting for a clock.

Optional Feature:
- Macro SELFTEST_LOOP_EN.
- Defined:
  - DONE lasts one cycle (done pulses), then the run automatically restarts at SETTLE with idx=0, without waiting for start.
  - fail_vec is sticky (OR across passes).
  - err_count accumulates, saturating at 7.
  - pass = (fail_vec==0).
  - Only abort or reset stops looping.
- Undefined: single-shot behaviour described above. Ports are identical in both builds.

Decomposition:
- Package selftest_pkg holds:
  - the state enum (IDLE, SETTLE, CHECK, DONE) with 2-bit encoding
  - NUM_VECTORS=4
  - an expected-output function of idx
- Sub-module settle_timer (load, value, tick, zero flag, parameterised CNT_W) is natural.
- Everything else stays in gate_selftest_ctrl.

Test Plan:
- Good AND model, SETTLE_CYCLES=4, start pulse at cycle 0:
  - drivers go 00, 01, 10, 11, each held 5 cycles
  - done=1 at cycle 21, pass=1, fail_vec=0000, err_count=0
- Gate model stuck-at-1: done with pass=0, fail_vec=0111, err_count=3.
- Gate model replaced by OR: fail_vec=0110, err_count=2, pass=0.
- abort asserted during vector 2 SETTLE, together with start:
  - IDLE next cycle, all outputs 0
  - a subsequent start runs a clean full sequence
- rst_n pulsed low mid-CHECK, asynchronously between clock edges: outputs 0 immediately; after release, IDLE until start.
- With SELFTEST_LOOP_EN and stuck-at-0 model, 3 loops:
  - done pulses one cycle each at cycles 21, 42 and 63
  - fail_vec=1000 sticky
  - err_count=3 after the third loop, saturating at 7 later
